// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_pkg
// Description : Endpoint addresses and shared types for the host wire bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

  localparam int WIRE_W = 32;

  // Opal Kelly wire endpoint addresses
  localparam logic [7:0] EP_CTRL      = 8'h00;
  localparam logic [7:0] EP_INSN_VLD  = 8'h03;
  localparam logic [7:0] EP_INSN_B0   = 8'h04;
  localparam logic [7:0] EP_INSN_B1   = 8'h05;
  localparam logic [7:0] EP_IN_VLD    = 8'h06;
  localparam logic [7:0] EP_IN_BITS   = 8'h07;
  localparam logic [7:0] EP_OUT_RDY   = 8'h08;
  localparam logic [7:0] EP_INSN_RDY  = 8'h20;
  localparam logic [7:0] EP_IN_RDY    = 8'h21;
  localparam logic [7:0] EP_OUT_VLD   = 8'h22;
  localparam logic [7:0] EP_OUT_BITS  = 8'h23;
  localparam logic [7:0] EP_STAT_INSN = 8'h24;
  localparam logic [7:0] EP_STAT_IN   = 8'h25;
  localparam logic [7:0] EP_STAT_OUT  = 8'h26;

  typedef struct packed {
    logic [WIRE_W-1:0] b1;
    logic [WIRE_W-1:0] b0;
  } insn_t;

endpackage
`default_nettype wire

// File: rtl/bridge_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bridge_fifo
// Description : Synchronous FIFO with push/pop/flush; a push on a full FIFO
//               is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_do_pop;
  logic            w_do_push;

  assign full      = (r_count == (c_aw+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by r_count.
  always_ff @(posedge clock) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/ok_wire_decoupled_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ok_wire_decoupled_bridge
// Description : Converts host-toggled Opal Kelly wires into core ready/valid
//               streams. Optional counters with macro BRIDGE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ok_wire_decoupled_bridge
  import bridge_pkg::*;
#(
  parameter int INSN_DEPTH = 4,
  parameter int IN_DEPTH   = 4,
  parameter int IO_W       = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIRE_W-1:0] wi_ctrl,
  input  logic [WIRE_W-1:0] wi_insn_vld,
  input  logic [WIRE_W-1:0] wi_insn_b0,
  input  logic [WIRE_W-1:0] wi_insn_b1,
  input  logic [WIRE_W-1:0] wi_in_vld,
  input  logic [WIRE_W-1:0] wi_in_bits,
  input  logic [WIRE_W-1:0] wi_out_rdy,
  output logic [WIRE_W-1:0] wo_insn_rdy,
  output logic [WIRE_W-1:0] wo_in_rdy,
  output logic [WIRE_W-1:0] wo_out_vld,
  output logic [WIRE_W-1:0] wo_out_bits,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [63:0]       insn_bits,
  output logic              in_valid,
  input  logic              in_ready,
  output logic [IO_W-1:0]   in_bits,
  input  logic              out_valid,
  output logic              out_ready,
  input  logic [IO_W-1:0]   out_bits
`ifdef BRIDGE_STATS_EN
  ,
  output logic [WIRE_W-1:0] wo_stat_insn,
  output logic [WIRE_W-1:0] wo_stat_in,
  output logic [WIRE_W-1:0] wo_stat_out
`endif
);

  logic                          w_clr;
  logic                          r_insn_prev, r_in_prev, r_out_prev;
  logic                          w_insn_evt, w_in_evt, w_out_evt;
  insn_t                         w_insn_word;
  logic                          w_insn_full, w_insn_empty, w_insn_pop, w_insn_accept;
  logic                          w_in_full, w_in_empty, w_in_pop, w_in_accept;
  logic [$clog2(INSN_DEPTH):0]   w_insn_count;
  logic [$clog2(IN_DEPTH):0]     w_in_count;
  logic                          r_insn_ovf, r_in_ovf;
  logic                          r_hold_full;
  logic [IO_W-1:0]               r_hold_data;
  logic                          w_out_load, w_out_clear;
  logic [WIRE_W-1:0]             w_out_word;
  logic                          w_unused_bits;

  assign w_clr = wi_ctrl[0];

  // Edge registers track the wires even during soft clear so a level held
  // across the clear does not fire afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_insn_prev <= 1'b0;
      r_in_prev   <= 1'b0;
      r_out_prev  <= 1'b0;
    end else begin
      r_insn_prev <= wi_insn_vld[0];
      r_in_prev   <= wi_in_vld[0];
      r_out_prev  <= wi_out_rdy[0];
    end
  end

  assign w_insn_evt = wi_insn_vld[0] & ~r_insn_prev & ~w_clr;
  assign w_in_evt   = wi_in_vld[0]   & ~r_in_prev   & ~w_clr;
  assign w_out_evt  = wi_out_rdy[0]  & ~r_out_prev  & ~w_clr;

  assign w_insn_word   = '{b1: wi_insn_b1, b0: wi_insn_b0};
  assign insn_valid    = ~w_insn_empty;
  assign w_insn_pop    = insn_valid & insn_ready;
  assign w_insn_accept = w_insn_evt & (~w_insn_full | w_insn_pop);

  bridge_fifo #(.W($bits(insn_t)), .DEPTH(INSN_DEPTH)) u_insn_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (w_clr),
    .push      (w_insn_evt),
    .push_data (w_insn_word),
    .pop       (w_insn_pop),
    .pop_data  (insn_bits),
    .full      (w_insn_full),
    .empty     (w_insn_empty),
    .count     (w_insn_count)
  );

  assign in_valid    = ~w_in_empty;
  assign w_in_pop    = in_valid & in_ready;
  assign w_in_accept = w_in_evt & (~w_in_full | w_in_pop);

  bridge_fifo #(.W(IO_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (w_clr),
    .push      (w_in_evt),
    .push_data (wi_in_bits[IO_W-1:0]),
    .pop       (w_in_pop),
    .pop_data  (in_bits),
    .full      (w_in_full),
    .empty     (w_in_empty),
    .count     (w_in_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_insn_ovf <= 1'b0;
      r_in_ovf   <= 1'b0;
    end else if (w_clr) begin
      r_insn_ovf <= 1'b0;
      r_in_ovf   <= 1'b0;
    end else begin
      if (w_insn_evt && !w_insn_accept) r_insn_ovf <= 1'b1;
      if (w_in_evt && !w_in_accept)     r_in_ovf   <= 1'b1;
    end
  end

  // out_ready is low while full, so load and clear are mutually exclusive.
  assign out_ready   = ~r_hold_full;
  assign w_out_load  = out_valid & out_ready;
  assign w_out_clear = w_out_evt & r_hold_full;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_clr || w_out_clear) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_out_load) begin
      r_hold_full <= 1'b1;
      r_hold_data <= out_bits;
    end
  end

  always_comb begin
    w_out_word             = '0;
    w_out_word[IO_W-1:0]   = r_hold_data;
  end

  assign wo_insn_rdy = {{(WIRE_W-2){1'b0}}, r_insn_ovf, ~w_insn_full};
  assign wo_in_rdy   = {{(WIRE_W-2){1'b0}}, r_in_ovf,   ~w_in_full};
  assign wo_out_vld  = {{(WIRE_W-1){1'b0}}, r_hold_full};
  assign wo_out_bits = w_out_word;

`ifdef BRIDGE_STATS_EN
  logic [WIRE_W-1:0] r_stat_insn, r_stat_in, r_stat_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_insn <= '0;
      r_stat_in   <= '0;
      r_stat_out  <= '0;
    end else if (w_clr) begin
      r_stat_insn <= '0;
      r_stat_in   <= '0;
      r_stat_out  <= '0;
    end else begin
      if (w_insn_accept) r_stat_insn <= r_stat_insn + 1'b1;
      if (w_in_accept)   r_stat_in   <= r_stat_in + 1'b1;
      if (w_out_clear)   r_stat_out  <= r_stat_out + 1'b1;
    end
  end

  assign wo_stat_insn = r_stat_insn;
  assign wo_stat_in   = r_stat_in;
  assign wo_stat_out  = r_stat_out;
`endif

  assign w_unused_bits = ^{wi_ctrl[WIRE_W-1:1], wi_insn_vld[WIRE_W-1:1],
                           wi_in_vld[WIRE_W-1:1], wi_out_rdy[WIRE_W-1:1],
                           wi_in_bits, w_insn_count, w_in_count};

endmodule
`default_nettype wire

// File: tb/tb_ok_wire_decoupled_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ok_wire_decoupled_bridge
// Description : Directed and randomized bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ok_wire_decoupled_bridge;

  localparam int INSN_DEPTH = 4;
  localparam int IN_DEPTH   = 4;
  localparam int IO_W       = 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] wi_ctrl = '0, wi_insn_vld = '0, wi_insn_b0 = '0, wi_insn_b1 = '0;
  logic [31:0] wi_in_vld = '0, wi_in_bits = '0, wi_out_rdy = '0;
  logic [31:0] wo_insn_rdy, wo_in_rdy, wo_out_vld, wo_out_bits;
  logic        insn_valid, in_valid, out_ready;
  logic        insn_ready = 1'b0, in_ready = 1'b0, out_valid = 1'b0;
  logic [63:0] insn_bits;
  logic [31:0] in_bits;
  logic [31:0] out_bits = '0;
`ifdef BRIDGE_STATS_EN
  logic [31:0] wo_stat_insn, wo_stat_in, wo_stat_out;
`endif

  int checks = 0;
  int errors = 0;

  ok_wire_decoupled_bridge #(.INSN_DEPTH(INSN_DEPTH), .IN_DEPTH(IN_DEPTH), .IO_W(IO_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .wi_ctrl(wi_ctrl), .wi_insn_vld(wi_insn_vld), .wi_insn_b0(wi_insn_b0),
    .wi_insn_b1(wi_insn_b1), .wi_in_vld(wi_in_vld), .wi_in_bits(wi_in_bits),
    .wi_out_rdy(wi_out_rdy),
    .wo_insn_rdy(wo_insn_rdy), .wo_in_rdy(wo_in_rdy), .wo_out_vld(wo_out_vld),
    .wo_out_bits(wo_out_bits),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_bits(insn_bits),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits)
`ifdef BRIDGE_STATS_EN
    , .wo_stat_insn(wo_stat_insn), .wo_stat_in(wo_stat_in), .wo_stat_out(wo_stat_out)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: what the host/core should observe ----------------
  logic [63:0] m_insn_q[$];
  logic [31:0] m_in_q[$];
  bit          m_insn_ovf = 0, m_in_ovf = 0;
  bit          m_hold_full = 0;
  logic [31:0] m_hold_data = '0;
  bit          m_pi = 0, m_pn = 0, m_po = 0;
  int unsigned m_st_insn = 0, m_st_in = 0, m_st_out = 0;
  bit          clr, ipop, npop, ievt, nevt, oevt, ifull, nfull;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_insn_q.delete(); m_in_q.delete();
      m_insn_ovf = 0; m_in_ovf = 0; m_hold_full = 0; m_hold_data = '0;
      m_pi = 0; m_pn = 0; m_po = 0;
      m_st_insn = 0; m_st_in = 0; m_st_out = 0;
    end else begin
      clr   = wi_ctrl[0];
      ipop  = (m_insn_q.size() != 0) && insn_ready;
      npop  = (m_in_q.size() != 0) && in_ready;
      ievt  = wi_insn_vld[0] && !m_pi && !clr;
      nevt  = wi_in_vld[0] && !m_pn && !clr;
      oevt  = wi_out_rdy[0] && !m_po && !clr;
      ifull = m_insn_q.size() == INSN_DEPTH;
      nfull = m_in_q.size() == IN_DEPTH;
      if (clr) begin
        m_insn_q.delete(); m_in_q.delete();
        m_insn_ovf = 0; m_in_ovf = 0; m_hold_full = 0; m_hold_data = '0;
        m_st_insn = 0; m_st_in = 0; m_st_out = 0;
      end else begin
        if (ipop) void'(m_insn_q.pop_front());
        if (npop) void'(m_in_q.pop_front());
        if (ievt) begin
          if (!ifull || ipop) begin m_insn_q.push_back({wi_insn_b1, wi_insn_b0}); m_st_insn++; end
          else m_insn_ovf = 1;
        end
        if (nevt) begin
          if (!nfull || npop) begin m_in_q.push_back(wi_in_bits); m_st_in++; end
          else m_in_ovf = 1;
        end
        if (oevt && m_hold_full) begin
          m_hold_full = 0; m_hold_data = '0; m_st_out++;
        end else if (out_valid && !m_hold_full) begin
          m_hold_full = 1; m_hold_data = out_bits;
        end
      end
      m_pi = wi_insn_vld[0]; m_pn = wi_in_vld[0]; m_po = wi_out_rdy[0];
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clock) begin
    chk("wo_insn_rdy", {32'd0, wo_insn_rdy},
        {62'd0, m_insn_ovf, (m_insn_q.size() != INSN_DEPTH)});
    chk("wo_in_rdy", {32'd0, wo_in_rdy}, {62'd0, m_in_ovf, (m_in_q.size() != IN_DEPTH)});
    chk("wo_out_vld", {32'd0, wo_out_vld}, {63'd0, m_hold_full});
    chk("wo_out_bits", {32'd0, wo_out_bits}, {32'd0, m_hold_data});
    chk("out_ready", {63'd0, out_ready}, {63'd0, !m_hold_full});
    chk("insn_valid", {63'd0, insn_valid}, {63'd0, m_insn_q.size() != 0});
    chk("in_valid", {63'd0, in_valid}, {63'd0, m_in_q.size() != 0});
    if (m_insn_q.size() != 0) chk("insn_bits", insn_bits, m_insn_q[0]);
    if (m_in_q.size() != 0)   chk("in_bits", {32'd0, in_bits}, {32'd0, m_in_q[0]});
`ifdef BRIDGE_STATS_EN
    chk("stat_insn", {32'd0, wo_stat_insn}, {32'd0, m_st_insn});
    chk("stat_in", {32'd0, wo_stat_in}, {32'd0, m_st_in});
    chk("stat_out", {32'd0, wo_stat_out}, {32'd0, m_st_out});
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic insn_toggle(input logic [31:0] b1, input logic [31:0] b0);
    wi_insn_b1 = b1; wi_insn_b0 = b0; wi_insn_vld = 32'd1;
    step();
    wi_insn_vld = 32'd0;
    step();
  endtask

  task automatic soft_clear();
    wi_ctrl = 32'd1; step();
    wi_ctrl = 32'd0; step();
  endtask

  int beats;

  initial begin
    #1 reset_n = 1'b0;
    #3;
    chk("reset_insn_rdy", {32'd0, wo_insn_rdy}, 64'd1);
    chk("reset_in_rdy", {32'd0, wo_in_rdy}, 64'd1);
    chk("reset_out_ready", {63'd0, out_ready}, 64'd1);
    step(); step();
    reset_n = 1'b1;
    step();

    // single instruction beat
    wi_insn_b1 = 32'h80; wi_insn_b0 = 32'h1; wi_insn_vld = 32'd1;
    step();
    chk("t2_valid", {63'd0, insn_valid}, 64'd1);
    chk("t2_bits", insn_bits, 64'h00000080_00000001);
    insn_ready = 1'b1; wi_insn_vld = 32'd0;
    step();
    chk("t2_one_beat", {63'd0, insn_valid}, 64'd0);

    // overflow: fifth push dropped, first four drained in order
    insn_ready = 1'b0;
    for (int i = 0; i < 5; i++) insn_toggle(32'd0, 32'h100 + i);
    chk("t3_ovf", {32'd0, wo_insn_rdy}, 64'h2);
    insn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_valid", {63'd0, insn_valid}, 64'd1);
      chk("t3_drain_bits", insn_bits, 64'h100 + i);
      step();
    end
    chk("t3_empty", {63'd0, insn_valid}, 64'd0);
    chk("t3_rdy", {32'd0, wo_insn_rdy}, 64'h3);
    soft_clear();

    // full FIFO with push and pop in the same cycle
    insn_ready = 1'b0;
    for (int i = 0; i < 4; i++) insn_toggle(32'd0, 32'h200 + i);
    chk("t4_full", {32'd0, wo_insn_rdy}, 64'h0);
    wi_insn_b0 = 32'h204; wi_insn_vld = 32'd1; insn_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 8; i++) begin
      if (insn_valid) beats++;
      step();
      wi_insn_vld = 32'd0;
    end
    chk("t4_beats", beats, 64'd5);
    chk("t4_no_ovf", {32'd0, wo_insn_rdy}, 64'h1);

    // output hold register
    out_valid = 1'b1; out_bits = 32'h9;
    step();
    out_valid = 1'b0;
    chk("t5_vld", {32'd0, wo_out_vld}, 64'd1);
    chk("t5_bits", {32'd0, wo_out_bits}, 64'h9);
    chk("t5_out_ready", {63'd0, out_ready}, 64'd0);
    wi_out_rdy = 32'd1; step();
    chk("t5_cleared", {32'd0, wo_out_vld}, 64'd0);
    chk("t5_bits0", {32'd0, wo_out_bits}, 64'd0);
    wi_out_rdy = 32'd0; step();
    wi_out_rdy = 32'd1; step();
    chk("t5_ignored", {32'd0, wo_out_vld}, 64'd0);
    wi_out_rdy = 32'd0; step();

    // soft clear with a held valid toggle
    insn_ready = 1'b0; in_ready = 1'b0;
    insn_toggle(32'd0, 32'h300);
    insn_toggle(32'd0, 32'h301);
    wi_in_bits = 32'h55; wi_in_vld = 32'd1; step(); wi_in_vld = 32'd0; step();
    chk("t6_in_valid_pre", {63'd0, in_valid}, 64'd1);
    wi_ctrl = 32'd1; wi_insn_vld = 32'd1;
    step();
    chk("t6_insn_valid", {63'd0, insn_valid}, 64'd0);
    chk("t6_in_valid", {63'd0, in_valid}, 64'd0);
    step();
    wi_ctrl = 32'd0;
    step();
    chk("t6_held_ignored", {63'd0, insn_valid}, 64'd0);
`ifdef BRIDGE_STATS_EN
    chk("t6_stat_insn", {32'd0, wo_stat_insn}, 64'd0);
`endif
    wi_insn_vld = 32'd0; step();

    // reset mid-stream
    insn_toggle(32'd0, 32'h400);
    insn_toggle(32'd0, 32'h401);
    out_valid = 1'b1; out_bits = 32'hA; step(); out_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("t1_insn_rdy", {32'd0, wo_insn_rdy}, 64'd1);
    chk("t1_insn_valid", {63'd0, insn_valid}, 64'd0);
    chk("t1_out_vld", {32'd0, wo_out_vld}, 64'd0);
    chk("t1_out_bits", {32'd0, wo_out_bits}, 64'd0);
    step();
    reset_n = 1'b1;
    step();

    // randomized traffic with phases that favour filling or draining
    for (int c = 0; c < 4000; c++) begin
      wi_insn_vld = {31'd0, $urandom_range(0, 2) == 0};
      wi_in_vld   = {31'd0, $urandom_range(0, 2) == 0};
      wi_out_rdy  = {31'd0, $urandom_range(0, 2) == 0};
      wi_insn_b0  = $urandom; wi_insn_b1 = $urandom; wi_in_bits = $urandom;
      wi_ctrl     = {31'd0, $urandom_range(0, 149) == 0};
      insn_ready  = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_ready    = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      out_valid   = $urandom_range(0, 1) == 1;
      out_bits    = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
